// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family (PISO transmit, SIPO receive):
// state encoding, shift-direction encoding and the bit-counter width helper.
package shift_reg_pkg;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    localparam bit SHIFT_LSB_FIRST = 1'b0;
    localparam bit SHIFT_MSB_FIRST = 1'b1;

    // Counter must hold 0..width-1, but never collapses below one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_register_if.sv
// Load handshake plus serial/framing outputs of the PISO block.
interface piso_shift_register_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             Q;
    logic             q_valid;
    logic             first_bit;
    logic             last_bit;

    modport master (
        output load_valid, load_data,
        input  load_ready, Q, q_valid, first_bit, last_bit
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, Q, q_valid, first_bit, last_bit
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: counts 0..WIDTH-1 while enabled, wraps to 0, flags the last bit.
module piso_bit_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign terminal = (cnt_reg == LAST);
    assign cnt      = cnt_reg;

    // Clear wins over enable so a reload on the terminal edge restarts at bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= terminal ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter with valid/ready load and first/last framing strobes;
// a word offered on the final bit's edge is loaded seamlessly.
module piso_shift_register
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = SHIFT_MSB_FIRST
) (
    input logic                   clk,
    input logic                   reset,
    piso_shift_register_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] cnt;
    logic             terminal;
    logic             load_ready;
    logic             accept;
    logic             in_shift;
    logic             q_bit;

    if (MSB_FIRST) begin : g_msb_first
        assign shreg_shifted = shreg_reg << 1;
        assign q_bit         = shreg_reg[WIDTH-1];
    end else begin : g_lsb_first
        assign shreg_shifted = shreg_reg >> 1;
        assign q_bit         = shreg_reg[0];
    end

    assign in_shift   = (state_reg == SHIFT);
    assign load_ready = (state_reg == IDLE) || (in_shift && terminal);
    assign accept     = bus.load_valid && load_ready;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (in_shift),
        .cnt      (cnt),
        .terminal (terminal)
    );

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        if (accept) begin
            state_next = SHIFT;
            shreg_next = bus.load_data;
        end else if (in_shift) begin
            // Zero fill means the register drains to 0 as the frame ends.
            shreg_next = shreg_shifted;
            if (terminal) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.Q          = q_bit;
    assign bus.q_valid    = in_shift;
    assign bus.first_bit  = in_shift && (cnt == '0);
    assign bus.last_bit   = in_shift && terminal;

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
Parallel-in serial-out shift register, WIDTH bits, with a valid/ready load handshake. It is the transmit-side counterpart of the team's SIPO block. Serializes one word per WIDTH clocks onto a single data line. It also emits framing strobes so a downstream deserializer or checker can align words. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word length in bits; legal range 1..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset: 0 clears all state immediately, independent of clk.
load_valid  input  1  sender offers load_data this cycle.
load_data  input  WIDTH  parallel word to serialize.
load_ready  output  1  block can accept a word on this edge.
Q  output  1  serial data out, registered.
q_valid  output  1  Q carries a frame bit this cycle.
first_bit  output  1  Q is bit 0 of the frame (first shifted).
last_bit  output  1  Q is the final bit of the frame.

Behaviour:
- States: IDLE, SHIFT. Internal: shreg[WIDTH-1:0]; bit counter cnt, width max(1, clog2(WIDTH)).
- Reset (reset=0, asynchronous):
  - state=IDLE, shreg=0, cnt=0.
  - Outputs: Q=0, q_valid=0, first_bit=0, last_bit=0, load_ready=1.
  - Applies mid-frame too: the frame is abandoned, with no partial completion.
- Q is the output bit of shreg: shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. Shifting fills with 0, so Q=0 whenever idle.
- load_ready is combinational: (state==IDLE) or (state==SHIFT and cnt==WIDTH-1). It never depends on load_valid.
- Accept = load_valid & load_ready at a rising edge. On accept: shreg<=load_data, cnt<=0, state<=SHIFT.
- Latency: with an accept on edge k, frame bit i appears on Q for the cycle after edge k+i, for i = 0..WIDTH-1.
- In SHIFT, on each edge:
  - If cnt<WIDTH-1: shift shreg by one toward the output end and set cnt<=cnt+1.
  - If cnt==WIDTH-1 and accept: reload as above. This gives a seamless next frame.
  - If cnt==WIDTH-1 and no accept: shift (shreg becomes 0), cnt<=0, state<=IDLE.
- q_valid = (state==SHIFT). first_bit = q_valid & (cnt==0). last_bit = q_valid & (cnt==WIDTH-1).
- load_valid while load_ready=0 is ignored. The sender must hold load_valid and load_data stable until accepted. load_data is don't-care while load_valid=0.
- WIDTH=1: first_bit and last_bit are high together, load_ready is always 1, and the block supports continuous 1-bit streaming.
- No X may propagate to Q or the strobes from an undriven load_data while idle.

Decomposition:
- Shared package shift_reg_pkg holds:
  - state typedef {IDLE, SHIFT};
  - a count-width function, max(1, clog2(WIDTH));
  - a shift-direction constant encoding, reused by the SIPO side.
- One natural sub-module: piso_bit_counter. It takes clk, reset, clear/load and enable, and outputs cnt and a terminal-count flag (cnt==WIDTH-1). The top level holds the FSM, shreg and the handshake.

Test Plan:
All scenarios use WIDTH=4, MSB_FIRST=1 and a 10 ns clock unless noted.
1. Hold reset=0 for 12 ns, then release, with load_valid=0 -> Q=0, q_valid=0, first_bit=0, last_bit=0, load_ready=1 at all times.
2. Single load of 4'b1011 -> Q=1,0,1,1 on four consecutive cycles. first_bit is high in cycle 1 only and last_bit in cycle 4 only. load_ready is low in cycles 1-3 and high in cycle 4. Afterwards q_valid=0 and Q=0.
3. Back-to-back: 4'b1011, then 4'b0110 held valid -> 4'b0110 is accepted on the last_bit edge. Q=1,0,1,1,0,1,1,0 contiguously, q_valid stays high for 8 cycles, and first_bit fires at cycles 1 and 5.
4. Frame 4'b1000, then load_valid=1 with 4'b1111 asserted during bit 1 -> no early capture, and the first frame completes as 1,0,0,0. 4'b1111 follows immediately as 1,1,1,1.
5. Drive reset=0 for 3 ns, between clock edges, after 2 bits of 4'b0101 -> Q, q_valid and the strobes drop to 0 before the next edge, and load_ready=1. After release, a load of 4'b1100 serializes as 1,1,0,0.
6. MSB_FIRST=0, load 4'b1011 -> Q=1,1,0,1. Repeat with WIDTH=1, loading 1,0,1 back-to-back -> Q=1,0,1, with first_bit=last_bit=1 for each bit.
